// File: rtl/pipe_xform_stream_if.sv
// pipe_xform_stream_if: valid/ready bundle for both sides of the
// transform pipe. slave = pipe side, master = producer/consumer side.
interface pipe_xform_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_xform_stream.sv
// pipe_xform_stream: DEPTH-stage back-pressured XOR/mask pipe.
// Optional PIPE_XFORM_STATS_EN adds saturating xfer/stall counters.
module pipe_xform_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] XOR_KEY = WIDTH'('hAA),
  parameter logic [WIDTH-1:0] LO_MASK =
    {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}},
  parameter logic [WIDTH-1:0] HI_MASK =
    {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}},
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_xform_stream_if.slave bus,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic [15:0]       xfer_count,
  output logic [15:0]       stall_count
);

  logic             r_v    [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [1:0]       r_mode [DEPTH];

  logic [DEPTH:0]   w_adv;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_out_data;
  logic [OCC_W-1:0] w_occ;

  // Ready chain: a stage moves if it is empty or its successor moves.
  always_comb begin
    logic w_chain;
    w_chain = bus.out_ready;
    w_adv[DEPTH] = w_chain;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_chain = !r_v[k] | w_chain;
      w_adv[k] = w_chain;
    end
  end

  assign bus.in_ready  = w_adv[0] & !flush;
  assign bus.out_valid = r_v[DEPTH-1] & !flush;
  assign w_in_fire     = bus.in_valid & bus.in_ready;

  // Valid bits: shift on advance, all cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        r_v[k] <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++)
        r_v[k] <= 1'b0;
    end else begin
      if (w_adv[0])
        r_v[0] <= bus.in_valid;
      for (int k = 1; k < DEPTH; k++)
        if (w_adv[k])
          r_v[k] <= r_v[k-1];
    end
  end

  // Payload: keyed on entry, copied only when a real beat moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
        r_mode[k] <= 2'b00;
      end
    end else if (!flush) begin
      if (w_in_fire) begin
        r_data[0] <= bus.in_data ^ XOR_KEY;
        r_mode[0] <= bus.in_mode;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_adv[k] && r_v[k-1]) begin
          r_data[k] <= r_data[k-1];
          r_mode[k] <= r_mode[k-1];
        end
      end
    end
  end

  // Output transform selected by the final stage's mode.
  always_comb begin
    w_out_data = r_data[DEPTH-1];
    unique case (r_mode[DEPTH-1])
      2'b00: w_out_data = r_data[DEPTH-1];
      2'b01: w_out_data = r_data[DEPTH-1] & LO_MASK;
      2'b10: w_out_data = r_data[DEPTH-1] | HI_MASK;
      2'b11: w_out_data = ~r_data[DEPTH-1];
    endcase
  end

  assign bus.out_data = w_out_data;

  // Occupancy is a popcount of the registered valid bits.
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++)
      w_occ = w_occ + OCC_W'(r_v[k]);
  end

  assign occupancy = w_occ;

`ifdef PIPE_XFORM_STATS_EN
  logic        w_out_fire;
  logic        w_out_stall;
  logic [15:0] r_xfer;
  logic [15:0] r_stall;

  assign w_out_fire  = bus.out_valid & bus.out_ready;
  assign w_out_stall = bus.out_valid & !bus.out_ready;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer  <= 16'h0000;
      r_stall <= 16'h0000;
    end else begin
      if (w_out_fire && r_xfer != 16'hFFFF)
        r_xfer <= r_xfer + 16'd1;
      if (w_out_stall && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign xfer_count  = r_xfer;
  assign stall_count = r_stall;
`else
  assign xfer_count  = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_xform_stream.sv
// tb_pipe_xform_stream: scoreboard bench for pipe_xform_stream
// at WIDTH=8, DEPTH=3, either stats build.
module tb_pipe_xform_stream;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
`ifdef PIPE_XFORM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] xfer_count;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit last_acc;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         acc_cyc_q[$];
  int         got_cyc_q[$];

  pipe_xform_stream_if #(.WIDTH(WIDTH)) bus ();

  pipe_xform_stream #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .flush(flush),
    .occupancy(occupancy),
    .xfer_count(xfer_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic [7:0] d,
                                       input logic [1:0] m);
    logic [7:0] x;
    x = d ^ 8'hAA;
    case (m)
      2'b00:   return x;
      2'b01:   return x & 8'h0F;
      2'b10:   return x | 8'hF0;
      default: return ~x;
    endcase
  endfunction

  // Advance one cycle; record handshakes at the falling edge.
  task automatic tick();
    @(negedge clk);
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) begin
      exp_q.push_back(model(bus.in_data, bus.in_mode));
      acc_cyc_q.push_back(cyc);
    end
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      got_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready);
    end
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("FAIL rst_occ: got %0d want 0", occupancy);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data: got %0h want 0", bus.out_data);
    end
    checks++;
    if (xfer_count !== 16'h0 || stall_count !== 16'h0) begin
      failures++;
      $display("FAIL rst_counts: got %0h/%0h want 0/0",
               xfer_count, stall_count);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_modes();
    logic [7:0] want [4];
    int n;
    want = '{8'h96, 8'h06, 8'hF6, 8'h69};
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h3C;
      bus.in_mode  = 2'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 4 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (got_q.size() != 4 || acc_cyc_q.size() != 4) begin
      failures++;
      $display("FAIL modes_count: got %0d/%0d want 4/4",
               got_q.size(), acc_cyc_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size()
         && i < acc_cyc_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want[i]) begin
        failures++;
        $display("FAIL modes_data%0d: got %0h want %0h",
                 i, got_q[i], want[i]);
      end
      checks++;
      if (got_cyc_q[i] - acc_cyc_q[i] != DEPTH) begin
        failures++;
        $display("FAIL modes_latency%0d: got %0d want %0d",
                 i, got_cyc_q[i] - acc_cyc_q[i], DEPTH);
      end
      checks++;
      if (got_cyc_q[i] != got_cyc_q[0] + i) begin
        failures++;
        $display("FAIL modes_cadence%0d: got %0d want %0d",
                 i, got_cyc_q[i], got_cyc_q[0] + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d [5];
    logic [7:0] g;
    logic [7:0] e;
    int idx;
    int n;
    d = '{8'h01, 8'h55, 8'hF0, 8'h7E, 8'hC3};
    apply_reset();
    idx = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d[0];
    bus.in_mode  = 2'd0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_c3: got %0b want 0", bus.in_ready);
        end
      end
      tick();
      if (last_acc) begin
        idx++;
        bus.in_data = d[idx % 5];
        bus.in_mode = 2'(idx % 4);
      end
    end
    checks++;
    if (idx != 3) begin
      failures++;
      $display("FAIL bp_accepted: got %0d want 3", idx);
    end
    checks++;
    if (occupancy !== 2'd3 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got occ=%0d rdy=%0b want 3/0",
               occupancy, bus.in_ready);
    end
    checks++;
    if (stall_count !== (STATS ? 16'd5 : 16'd0)) begin
      failures++;
      $display("FAIL bp_stall: got %0d want %0d",
               stall_count, STATS ? 5 : 0);
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (got_q.size() < 5 && n < 50) begin
      tick();
      n++;
      if (last_acc) begin
        idx++;
        if (idx < 5) begin
          bus.in_data = d[idx];
          bus.in_mode = 2'(idx % 4);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (got_q.size() != 5) begin
      failures++;
      $display("FAIL bp_count: got %0d want 5", got_q.size());
    end
    for (int i = 0; got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bp_extra: got %0h want none", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e || e !== model(d[i % 5], 2'(i % 4))) begin
          failures++;
          $display("FAIL bp_data%0d: got %0h want %0h", i, g,
                   model(d[i % 5], 2'(i % 4)));
        end
      end
    end
    checks++;
    if (xfer_count !== (STATS ? 16'd5 : 16'd0)
        || stall_count !== (STATS ? 16'd5 : 16'd0)) begin
      failures++;
      $display("FAIL bp_stats: got %0d/%0d want %0d/%0d",
               xfer_count, stall_count,
               STATS ? 5 : 0, STATS ? 5 : 0);
    end
  endtask

  task automatic test_bubble();
    logic [7:0] g;
    logic [7:0] e;
    int n;
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h12;
    bus.in_mode  = 2'b11;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (occupancy !== 2'd1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bub_one: got occ=%0d ov=%0b want 1/1",
               occupancy, bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h34;
    bus.in_mode  = 2'b01;
    tick();
    checks++;
    if (!last_acc || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bub_second: got acc=%0b rdy=%0b want 1/1",
               last_acc, bus.in_ready);
    end
    bus.in_data = 8'h56;
    bus.in_mode = 2'b10;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (!last_acc || occupancy !== 2'd3 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bub_full: got acc=%0b occ=%0d rdy=%0b want 1/3/0",
               last_acc, occupancy, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (got_q.size() < 3 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL bub_count: got %0d want 3", got_q.size());
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bub_extra: got %0h want none", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL bub_data: got %0h want %0h", g, e);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] e;
    int n;
    apply_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'h20 + 8'(i);
      bus.in_mode = 2'(i);
      tick();
    end
    checks++;
    if (occupancy !== 2'd3) begin
      failures++;
      $display("FAIL fl_pre_occ: got %0d want 3", occupancy);
    end
    flush = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = 8'hEE;
    bus.in_mode = 2'b00;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fl_comb: got rdy=%0b ov=%0b want 0/0",
               bus.in_ready, bus.out_valid);
    end
    tick();
    checks++;
    if (last_acc || got_q.size() != 0) begin
      failures++;
      $display("FAIL fl_xfer: got acc=%0b out=%0d want 0/0",
               last_acc, got_q.size());
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fl_post: got occ=%0d ov=%0b want 0/0",
               occupancy, bus.out_valid);
    end
    repeat (4) tick();
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL fl_leak: got %0d beats want 0", got_q.size());
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h81;
    bus.in_mode  = 2'b10;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL fl_after: got %0d/%0d want 1/1",
               got_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (got_q.pop_front() !== e || e !== 8'hFB) begin
        failures++;
        $display("FAIL fl_after_data: got %0h want fb", e);
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'h40 + 8'(i);
      bus.in_mode = 2'(i % 4);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL ar_state: got ov=%0b occ=%0d want 0/0",
               bus.out_valid, occupancy);
    end
    checks++;
    if (xfer_count !== 16'h0 || stall_count !== 16'h0) begin
      failures++;
      $display("FAIL ar_counts: got %0h/%0h want 0/0",
               xfer_count, stall_count);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    got_cyc_q.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_mode  = 2'b00;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (got_q.size() != 1 || acc_cyc_q.size() != 1) begin
      failures++;
      $display("FAIL ar_count: got %0d want 1", got_q.size());
    end else if (got_q[0] !== 8'h0F
                 || got_cyc_q[0] - acc_cyc_q[0] != DEPTH) begin
      failures++;
      $display("FAIL ar_beat: got %0h lat %0d want 0f lat %0d",
               got_q[0], got_cyc_q[0] - acc_cyc_q[0], DEPTH);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    repeat (70010) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (xfer_count !== (STATS ? 16'hFFFF : 16'h0000)) begin
      failures++;
      $display("FAIL sat_xfer: got %0h want %0h",
               xfer_count, STATS ? 16'hFFFF : 16'h0000);
    end
    checks++;
    if (stall_count !== 16'h0000) begin
      failures++;
      $display("FAIL sat_stall: got %0h want 0", stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_xform_stream.md
# pipe_xform_stream

Parametrised, back-pressured successor to the fixed three-stage input/XOR/mask datapath. It carries a WIDTH-bit word and a 2-bit per-beat mode through DEPTH register stages with a valid/ready handshake on both sides. It applies a constant XOR key on entry and a mode-selected output transform, so one instance serves any width, depth or mask flavour. It sits between a producer and a consumer that can both stall.

## Interface
- WIDTH, 8, data width (≥2, even)
- DEPTH, 3, number of register stages (≥1)
- XOR_KEY, 'hAA, WIDTH-bit key XORed into data on entry (truncated/zero-extended to WIDTH)
- LO_MASK, lower WIDTH/2 bits set ('h0F at WIDTH=8), mask for AND mode
- HI_MASK, upper WIDTH/2 bits set ('hF0 at WIDTH=8), mask for OR mode
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  WIDTH  input word
- in_mode  in  2  per-beat transform: 00 pass, 01 AND LO_MASK, 10 OR HI_MASK, 11 invert
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  WIDTH  transformed word
- flush  in  1  synchronous discard of all in-flight beats
- occupancy  out  $clog2(DEPTH+1)  number of valid stages
- xfer_count  out  16  completed output transfers (see Configuration)
- stall_count  out  16  cycles with out_valid & !out_ready (see Configuration)

## Operation
- Stage k holds {v[k], data[k], mode[k]}, k=0..DEPTH-1; stage DEPTH-1 drives the output.
- Stage 0 loads in_data ^ XOR_KEY and in_mode on input handshake; stage k>0 copies stage k-1 unchanged.
- out_data = f(mode[DEPTH-1], data[DEPTH-1]): 00 data; 01 data & LO_MASK; 10 data | HI_MASK; 11 ~data. Combinational from final-stage registers.
- Advance: adv[DEPTH] = out_ready; adv[k] = !v[k] | adv[k+1]. Stage k loads from its upstream when adv[k]; v[k] <= v[k-1] (v[-1] = in_valid).
- in_ready = adv[0] & !flush. Bubbles collapse: a stalled output does not block input while any upstream stage is empty.
- out_valid = v[DEPTH-1] & !flush.
- flush: next edge clears every v[k]; no input accepted and no output transferred in that cycle; data/mode registers hold.
- occupancy = popcount(v), registered-state derived.
- Reset: all v = 0, data = 0, mode = 00; hence out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0, xfer_count = 0, stall_count = 0. Reset mid-stream drops all beats.

## Timing
- Latency: beat accepted in cycle t is presented with out_valid in cycle t+DEPTH if never stalled.
- Throughput: one beat/cycle with out_ready held high.
- Full: all v = 1 and out_ready = 0 → in_ready = 0 the same cycle (combinational ready chain).
- Full with out_ready = 1: output transfer and input accept occur in the same cycle; occupancy unchanged.
- Empty: out_valid = 0; out_data reflects stale final-stage registers and is don't-care.
- in_valid with in_ready = 0: producer holds in_data/in_mode; no beat lost or duplicated.

## Configuration
- PIPE_XFORM_STATS_EN defined: xfer_count increments on out_valid & out_ready; stall_count increments on out_valid & !out_ready. Both saturate at 16'hFFFF, clear only on reset, and are unaffected by flush.
- Not defined: no counter registers; xfer_count and stall_count tied to 16'h0000. Ports are present in both builds.

## Test plan
- WIDTH=8, DEPTH=3, out_ready=1; send 0x3C with modes 00, 01, 10, 11 on consecutive cycles → out_data 0x96, 0x06, 0xF6, 0x69 starting 3 cycles after the first accept, then one per cycle.
- out_ready=0 while streaming 5 beats → exactly 3 accepted, in_ready=0 from cycle 3, occupancy=3. Release out_ready → the 5 beats emerge in order, no loss or duplication. With stats enabled, stall_count equals the stalled cycles.
- Bubble collapse: single beat, stall output, then send 2 more → 3 beats held, in_ready drops only when occupancy=3.
- flush with occupancy=3 → next cycle occupancy=0, out_valid=0, and the beat offered during the flush cycle is not accepted.
- Assert rst_n low asynchronously mid-stream → out_valid, occupancy and counters are 0 immediately. After release, the first new beat appears 3 cycles after accept.
- Stats build: 70000 back-to-back transfers → xfer_count = 0xFFFF (saturated). Non-stats build → both counts stay 0.
